// File: rtl/nes_pkg.sv
// Shared definitions for the NES controller reader: FSM states, button bit
// positions inside the $4016-style byte, and the default phase length.
package nes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_BIT_LO = 3'd2,
    ST_BIT_HI = 3'd3,
    ST_DONE   = 3'd4
  } nes_state_t;

  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

  localparam int TICK_CYCLES_DEFAULT = 300;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous controller data line.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/nes_pad_reader.sv
// Reads one 8-bit frame from an NES controller per start request, driving the
// latch/clock strobes with TICK_CYCLES-long phases and publishing active-high buttons.
module nes_pad_reader
  import nes_pkg::*;
#(
  parameter int TICK_CYCLES = TICK_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons,
  output logic       valid,
  output logic       busy
);

  localparam int CNT_W = $clog2(2 * TICK_CYCLES + 1);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2 * TICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_CYCLES - 1);

  nes_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       idx, idx_next;
  logic [7:0]       shift, shift_next;
  logic             pad_data_sync;

  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pad_data),
    .q       (pad_data_sync)
  );

  always_comb begin
    state_next = state;
    cnt_next   = cnt + CNT_W'(1);
    idx_next   = idx;
    shift_next = shift;
    unique case (state)
      ST_IDLE: begin
        cnt_next = '0;
        if (start) state_next = ST_LATCH;
      end
      ST_LATCH: begin
        if (cnt == LATCH_LAST) begin
          state_next = ST_BIT_LO;
          cnt_next   = '0;
          idx_next   = 3'd0;
        end
      end
      ST_BIT_LO: begin
        // Sample at the very end of the low phase so the pad line has settled.
        if (cnt == TICK_LAST) begin
          shift_next = {shift[6:0], ~pad_data_sync};
          cnt_next   = '0;
          state_next = (idx == 3'd7) ? ST_DONE : ST_BIT_HI;
        end
      end
      ST_BIT_HI: begin
        if (cnt == TICK_LAST) begin
          state_next = ST_BIT_LO;
          cnt_next   = '0;
          idx_next   = idx + 3'd1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      idx       <= 3'd0;
      shift     <= 8'h00;
      pad_latch <= 1'b0;
      pad_clk   <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      buttons   <= 8'h00;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      idx       <= idx_next;
      shift     <= shift_next;
      pad_latch <= (state_next == ST_LATCH);
      pad_clk   <= (state_next == ST_BIT_HI);
      valid     <= (state_next == ST_DONE);
      busy      <= (state_next != ST_IDLE);
      if (state_next == ST_DONE) buttons <= shift_next;
    end
  end

endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader: a behavioural 4021-style controller model plus
// per-scenario tasks checking frame timing, decoded buttons and reset behaviour.
module tb_nes_pad_reader;

  localparam int T = 4;
  localparam int LAT = 17 * T + 1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] buttons;
  logic       valid;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nes_pad_reader #(.TICK_CYCLES(T)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .pad_data  (pad_data),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .buttons   (buttons),
    .valid     (valid),
    .busy      (busy)
  );

  // Controller model: parallel-load pressed buttons while latched, shift on each clk rise.
  logic [7:0] ctrl_pat = 8'h00;
  logic       ctrl_conn = 1'b1;
  logic [7:0] ctrl_sr;
  logic       ctrl_pclk_q;

  always @(posedge clk) begin
    if (!reset_n) begin
      ctrl_sr     <= 8'h00;
      ctrl_pclk_q <= 1'b0;
    end else begin
      if (pad_latch) ctrl_sr <= ctrl_pat;
      else if (pad_clk && !ctrl_pclk_q) ctrl_sr <= {ctrl_sr[6:0], 1'b0};
      ctrl_pclk_q <= pad_clk;
    end
  end

  assign pad_data = ctrl_conn ? ~ctrl_sr[7] : 1'b1;

  // Running protocol statistics observed just after each rising edge.
  int   latch_cyc = 0;
  int   clkhi_cyc = 0;
  int   clk_rise  = 0;
  int   valid_cnt = 0;
  int   viol      = 0;
  int   bad_run   = 0;
  int   run       = 0;
  logic mon_pclk  = 1'b0;
  logic mon_valid = 1'b0;

  always @(posedge clk) begin
    #1;
    if (pad_latch === 1'b1) latch_cyc++;
    if (pad_clk === 1'b1) clkhi_cyc++;
    if (pad_clk === 1'b1 && !mon_pclk) clk_rise++;
    if (valid === 1'b1) valid_cnt++;
    if (pad_latch === 1'b1 && pad_clk === 1'b1) viol++;
    if (valid === 1'b1 && mon_valid) viol++;
    if (pad_clk !== 1'b1 && mon_pclk && run != T && reset_n === 1'b1) bad_run++;
    run       = (pad_clk === 1'b1) ? run + 1 : 0;
    mon_pclk  = (pad_clk === 1'b1);
    mon_valid = (valid === 1'b1);
  end

  task automatic test_reset;
    reset_n = 1'b0;
    start   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({pad_latch, pad_clk, valid, busy, buttons} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=000", {pad_latch, pad_clk, valid, busy, buttons});
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] pat, input logic conn, input string tag);
    int v0, l0, h0, r0, b0, n;
    logic got;
    logic [7:0] exp;
    exp = conn ? pat : 8'h00;
    @(negedge clk);
    ctrl_pat  = pat;
    ctrl_conn = conn;
    v0 = valid_cnt; l0 = latch_cyc; h0 = clkhi_cyc; r0 = clk_rise; b0 = bad_run;
    start = 1'b1;
    got = 1'b0;
    n = 0;
    while (!got && n < 200) begin
      @(posedge clk);
      n++;
      #1;
      start = 1'b0;
      if (valid === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || n != LAT) begin
      errors++;
      $display("FAIL %s latency got=%0d want=%0d", tag, got ? n : -1, LAT);
    end
    checks++;
    if (buttons !== exp) begin
      errors++;
      $display("FAIL %s buttons got=%h want=%h", tag, buttons, exp);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (valid_cnt - v0 != 1) begin
      errors++;
      $display("FAIL %s valid_pulses got=%0d want=1", tag, valid_cnt - v0);
    end
    checks++;
    if (latch_cyc - l0 != 2 * T) begin
      errors++;
      $display("FAIL %s latch_cycles got=%0d want=%0d", tag, latch_cyc - l0, 2 * T);
    end
    checks++;
    if (clk_rise - r0 != 7 || clkhi_cyc - h0 != 7 * T || bad_run != b0) begin
      errors++;
      $display("FAIL %s pad_clk pulses=%0d high=%0d badruns=%0d want 7/%0d/0",
               tag, clk_rise - r0, clkhi_cyc - h0, bad_run - b0, 7 * T);
    end
    checks++;
    if (busy !== 1'b0 || buttons !== exp) begin
      errors++;
      $display("FAIL %s idle_hold busy=%b buttons=%h want 0/%h", tag, busy, buttons, exp);
    end
  endtask

  task automatic test_a_only;
    run_frame(8'h80, 1'b1, "a_only");
  endtask

  task automatic test_pattern;
    run_frame(8'h5A, 1'b1, "pattern_5a");
  endtask

  task automatic test_disconnected;
    run_frame(8'hFF, 1'b0, "disconnected");
  endtask

  task automatic test_random;
    logic [7:0] pat;
    for (int i = 0; i < 4; i++) begin
      pat = 8'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_frame(pat, 1'b1, "random");
    end
  endtask

  task automatic test_hold;
    logic [7:0] prev;
    int v0;
    prev = buttons;
    v0 = valid_cnt;
    repeat (30) @(negedge clk);
    checks++;
    if (buttons !== prev || valid_cnt != v0) begin
      errors++;
      $display("FAIL hold buttons=%h valids=%0d want %h/0", buttons, valid_cnt - v0, prev);
    end
  endtask

  task automatic test_start_ignored;
    int v0, vat;
    logic b69, b70;
    @(negedge clk);
    ctrl_pat  = 8'h3C;
    ctrl_conn = 1'b1;
    v0 = valid_cnt;
    vat = -1;
    b69 = 1'b0;
    b70 = 1'b1;
    start = 1'b1;
    for (int n = 1; n <= 110; n++) begin
      @(posedge clk);
      #1;
      if (valid === 1'b1 && vat < 0) vat = n;
      if (n == LAT) b69 = busy;
      if (n == LAT + 1) b70 = busy;
      @(negedge clk);
      start = (n == 10 || n == 40 || n == LAT);
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_cnt - v0 != 1 || vat != LAT) begin
      errors++;
      $display("FAIL start_ignored valids=%0d at=%0d want 1 at %0d", valid_cnt - v0, vat, LAT);
    end
    checks++;
    if (b69 !== 1'b1 || b70 !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored_busy done=%b after=%b end=%b want 1/0/0", b69, b70, busy);
    end
    checks++;
    if (buttons !== 8'h3C) begin
      errors++;
      $display("FAIL start_ignored_buttons got=%h want=3c", buttons);
    end
  endtask

  task automatic test_reset_mid;
    int r0, v0, n;
    @(negedge clk);
    ctrl_pat  = 8'hA5;
    ctrl_conn = 1'b1;
    r0 = clk_rise;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (clk_rise - r0 < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (clk_rise - r0 < 4) begin
      errors++;
      $display("FAIL reset_mid_reach rises=%0d want=4", clk_rise - r0);
    end
    @(negedge clk);
    v0 = valid_cnt;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({pad_latch, pad_clk, valid, busy, buttons} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_outputs got=%h want=000", {pad_latch, pad_clk, valid, busy, buttons});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (120) @(negedge clk);
    checks++;
    if (valid_cnt != v0 || busy !== 1'b0 || buttons !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_after valids=%0d busy=%b buttons=%h want 0/0/00",
               valid_cnt - v0, busy, buttons);
    end
    run_frame(8'($urandom), 1'b1, "after_reset");
  endtask

  task automatic test_invariants;
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL invariants violations=%0d want=0", viol);
    end
  endtask

  initial begin
    test_reset;
    test_a_only;
    test_pattern;
    test_disconnected;
    test_random;
    test_hold;
    test_start_ignored;
    test_reset_mid;
    test_invariants;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nes_pad_reader.md
NES_PAD_READER -- requirements
Module: nes_pad_reader

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 300, meaning clk cycles per protocol phase (6 us at 50 MHz); legal values are >= 4.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to read the controller once.
REQ-005 SHALL have port pad_data  input  1  serial data from the physical controller; active-low, asynchronous.
REQ-006 SHALL have port pad_latch  output  1  controller latch/strobe, registered.
REQ-007 SHALL have port pad_clk  output  1  controller shift clock, registered.
REQ-008 SHALL have port buttons  output  8  last completed frame, {A,B,Select,Start,Up,Down,Left,Right}, 1 = pressed; this matches the keystates/$4016 byte format.
REQ-009 SHALL have port valid  output  1  one-cycle pulse when buttons updates.
REQ-010 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-011 SHALL pass pad_data through a 2-flop synchronizer before any use.
REQ-012 SHALL implement the states IDLE, LATCH, BIT_LO, BIT_HI and DONE.
REQ-013 IDLE SHALL drive pad_latch=0 and pad_clk=0; start=1 SHALL move to LATCH on the next cycle.
REQ-014 LATCH SHALL hold pad_latch=1 for exactly 2*TICK_CYCLES cycles, then go to BIT_LO with bit index 0.
REQ-015 BIT_LO SHALL hold pad_clk=0 for TICK_CYCLES cycles and, on its last cycle, shift the shift register as {shift[6:0], ~pad_data_sync}.
REQ-016 After sampling in BIT_LO: index < 7 SHALL go to BIT_HI; index = 7 SHALL go to DONE.
REQ-017 BIT_HI SHALL hold pad_clk=1 for TICK_CYCLES cycles, then increment the bit index and return to BIT_LO.
REQ-018 DONE SHALL last 1 cycle, load buttons from the shift register, pulse valid, and return to IDLE.
REQ-019 The first sampled bit SHALL be A and SHALL end in buttons[7]; the last sampled bit SHALL be Right and SHALL end in buttons[0].
REQ-020 valid SHALL assert exactly 17*TICK_CYCLES+1 cycles after the cycle where start was accepted.
REQ-021 start while busy=1, including the DONE cycle, SHALL be ignored and SHALL NOT be queued.
REQ-022 buttons SHALL change only in DONE and SHALL hold its value between frames.
REQ-023 A disconnected controller (pad_data held high) SHALL yield buttons=8'h00.
REQ-024 The phase counter SHALL be wide enough for 2*TICK_CYCLES and SHALL reload to 0 on every state change; it SHALL never wrap inside a phase.
REQ-025 pad_latch and pad_clk SHALL never be high in the same cycle.

Reset
REQ-026 While reset_n=0 at a clk edge: state=IDLE; pad_latch=0, pad_clk=0, valid=0, busy=0; buttons=8'h00; shift register, bit index, phase counter and synchronizer=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame without a valid pulse; the first frame after reset SHALL need a new start.

Structure
REQ-028 The state enum, the button bit-index constants (BTN_A=7 ... BTN_RIGHT=0) and the default TICK_CYCLES SHALL live in shared package nes_pkg.
REQ-029 The synchronizer SHALL be a separate sub-module sync_2ff; the rest SHALL be one FSM module.

Verification (TICK_CYCLES=4)
REQ-030 Controller model presents only A pressed, start pulsed -> pad_latch high 8 cycles, 7 pad_clk pulses each high 4 cycles, valid at cycle 69, buttons=8'h80.
REQ-031 Model presents pattern 8'b0101_1010 (pressed bits), start pulsed -> buttons=8'h5A, exactly one valid pulse.
REQ-032 pad_data tied high, start pulsed -> buttons=8'h00, valid pulsed once.
REQ-033 start pulsed again at cycles 10, 40 and the DONE cycle -> no extra frame; busy stays high until after DONE; only 1 valid.
REQ-034 reset_n=0 during BIT_HI of bit 3 -> outputs all 0 next cycle, no valid pulse, buttons=8'h00; a later start gives a full correct frame.
REQ-035 Assertion run over all tests -> pad_latch & pad_clk never both 1; valid is never high for 2 consecutive cycles.
